serial_adder: RTL and testbench

Bit-serial N-bit adder: accepts two WIDTH-bit operands plus carry-in on a start handshake, then adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop. It returns the sum, carry-out and a one-cycle done pulse. It is the addition counterpart to the team's combinational subtractor cell, and serves as the low-area arithmetic path where latency is not critical.

---
 rtl/serial_adder_pkg.sv | 11 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full-adder cell used by serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_sr_q;
  logic [WIDTH-1:0]   b_sr_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic               done_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q;
`endif

  logic fa_s_c;
  logic fa_co_c;
  logic last_bit_c;

  // Single shared full-adder cell fed by the operand LSBs and the carry flop
  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s_c),
    .cout (fa_co_c)
  );

  assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

  // Control FSM with operand/sum shift registers and registered result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= {fa_s_c, sum_q[WIDTH-1:1]};
          a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
          carry_q <= fa_co_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit_c) begin
            cout_q  <= fa_co_c;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB is carry_q; carry out is the cell's carry
            ovf_q   <= carry_q ^ fa_co_c;
`endif
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Reference: unsigned sum with carry, and signed range test for overflow
  function automatic logic [W:0] ref_full(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    int sx, sy, s;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    s  = sx + sy + int'(c);
    return (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
  endfunction

  // Called at a negedge: present one start, return at the negedge where done is seen.
  // lat = posedges after the sampling edge until done is visible; got=0 on timeout.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output int lat, output bit got, output bit busy_ok);
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    got = 1'b0; lat = 0; busy_ok = 1'b1;
    for (int i = 0; i < int'(W) + 4; i++) begin
      if (done) begin
        got = 1'b1; lat = i;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%0b want=0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", ovf); end
`endif
  endtask

  task automatic check_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv);
    int lat; bit got, bok; logic [W:0] ef;
    ef = ref_full(av, bv, cv);
    launch(av, bv, cv, lat, got, bok);
    total++; if (!got) begin bad++; $display("FAIL %s_done_timeout got=none want=pulse", nm); end
    if (got) begin
      total++; if (lat != int'(W)) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, W); end
      total++; if (!bok) begin bad++; $display("FAIL %s_busy_profile got=bad want=high_until_done", nm); end
      total++; if (sum !== ef[W-1:0]) begin bad++; $display("FAIL %s_sum got=%h want=%h", nm, sum, ef[W-1:0]); end
      total++; if (cout !== ef[W]) begin bad++; $display("FAIL %s_cout got=%0b want=%0b", nm, cout, ef[W]); end
`ifdef SERIAL_ADDER_OVF_EN
      total++; if (ovf !== ref_ovf(av, bv, cv)) begin bad++; $display("FAIL %s_ovf got=%0b want=%0b", nm, ovf, ref_ovf(av, bv, cv)); end
`endif
    end
  endtask

  task automatic test_directed();
    @(negedge clk);
    check_op("d5a3c", 8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    // done lasts one cycle and result is held while idle
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_width got=%0b want=0", done); end
    total++; if (sum !== 8'h96) begin bad++; $display("FAIL hold_sum got=%h want=96", sum); end
    check_op("dff01", 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    check_op("bffff", 8'hFF, 8'hFF, 1'b1);
    // Still in the done cycle: start again immediately
    check_op("b_next", 8'h01, 8'h02, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    start = 1'b1; a = 8'h00; b = 8'h00; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < int'(W) + 6; i++) begin
      if (i == 3 || i == 5) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) dones++;
      @(negedge clk);
    end
    start = 1'b0;
    total++; if (dones != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL ignore_sum got=%h want=00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL ignore_cout got=%0b want=0", cout); end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", busy); end
    total++; if (sum !== '0) begin bad++; $display("FAIL midrst_sum got=%h want=00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL midrst_cout got=%0b want=0", cout); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
    check_op("after_rst", 8'h80, 8'h80, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv; logic cv;
    for (int n = 0; n < 40; n++) begin
      av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
      check_op("rand", av, bv, cv);
      // Every other op runs back-to-back from the done cycle
      if (n % 2 == 1) begin
        for (int k = 0; k < int'($urandom_range(3, 1)); k++) @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
